// File: rtl/vga_bus_pipe.sv
// Fixed-latency delay line for a VGA timing bus (counts, syncs, blanks, rgb),
// with optional rgb blanking and a frame-start pulse/counter taken at the output.
module vga_bus_pipe #(
   parameter int unsigned HC_W        = 11,
   parameter int unsigned VC_W        = 11,
   parameter int unsigned RGB_W       = 12,
   parameter int unsigned DELAY       = 1,
   parameter bit          BLANK_FORCE = 1'b1,
   parameter bit          SYNC_POL    = 1'b0,
   parameter int unsigned FRAME_W     = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [HC_W-1:0]    in_hcount,
   input  logic [VC_W-1:0]    in_vcount,
   input  logic               in_hsync,
   input  logic               in_vsync,
   input  logic               in_hblnk,
   input  logic               in_vblnk,
   input  logic [RGB_W-1:0]   in_rgb,
   output logic [HC_W-1:0]    out_hcount,
   output logic [VC_W-1:0]    out_vcount,
   output logic               out_hsync,
   output logic               out_vsync,
   output logic               out_hblnk,
   output logic               out_vblnk,
   output logic [RGB_W-1:0]   out_rgb,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam int unsigned BUS_W = HC_W + VC_W + 4 + RGB_W;

   generate
      if (DELAY < 1 || DELAY > 16) begin : g_bad_delay
         $error("vga_bus_pipe: DELAY must be in the range 1..16");
      end
   endgenerate

   // No handshake: one pixel is accepted every clock, there is no stall path.
   logic [BUS_W-1:0] bus_in;
   logic [BUS_W-1:0] stage [DELAY];
   logic [RGB_W-1:0] rgb_d;
   logic             blank_d;
   logic             vs_q;

   assign bus_in = {in_hcount, in_vcount, in_hsync, in_vsync, in_hblnk, in_vblnk, in_rgb};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DELAY); i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= bus_in;
         for (int i = 1; i < int'(DELAY); i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign {out_hcount, out_vcount, out_hsync, out_vsync, out_hblnk, out_vblnk, rgb_d} =
          stage[DELAY-1];

   // Blanking is applied after the last stage so it costs no extra latency.
   assign blank_d = out_hblnk | out_vblnk;
   assign out_rgb = (BLANK_FORCE && blank_d) ? '0 : rgb_d;

   // vs_q resets to 0, so with active-low sync the reset-cleared output is not an edge.
   assign frame_start = (out_vsync == SYNC_POL) && (vs_q != SYNC_POL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs_q      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         vs_q <= out_vsync;
         if (frame_start) begin
            frame_cnt <= frame_cnt + FRAME_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_vga_bus_pipe.sv
// Bench for vga_bus_pipe: two instances (DELAY=3 active-low/forced blanking, DELAY=4
// active-high/no forcing) share one input bus and are scored against delayed expectations.
module tb_vga_bus_pipe;

   localparam int HC_W    = 11;
   localparam int VC_W    = 11;
   localparam int RGB_W   = 12;
   localparam int DELAY_A = 3;
   localparam int DELAY_B = 4;
   localparam int FW_A    = 2;
   localparam int FW_B    = 16;
   localparam int TW      = HC_W + VC_W + 4;
   localparam int EXP_W   = TW + RGB_W;
   localparam int VS_BIT  = RGB_W + 2;
   localparam int H_TOT   = 20;
   localparam int V_TOT   = 12;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [HC_W-1:0]   in_hcount = '0;
   logic [VC_W-1:0]   in_vcount = '0;
   logic              in_hsync = 1'b0, in_vsync = 1'b0, in_hblnk = 1'b0, in_vblnk = 1'b0;
   logic [RGB_W-1:0]  in_rgb = '0;

   logic [HC_W-1:0]   hcount_a, hcount_b;
   logic [VC_W-1:0]   vcount_a, vcount_b;
   logic              hsync_a, vsync_a, hblnk_a, vblnk_a, start_a;
   logic              hsync_b, vsync_b, hblnk_b, vblnk_b, start_b;
   logic [RGB_W-1:0]  rgb_a, rgb_b;
   logic [FW_A-1:0]   fcnt_a;
   logic [FW_B-1:0]   fcnt_b;

   vga_bus_pipe #(.HC_W(HC_W), .VC_W(VC_W), .RGB_W(RGB_W), .DELAY(DELAY_A),
                  .BLANK_FORCE(1'b1), .SYNC_POL(1'b0), .FRAME_W(FW_A)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .in_hcount(in_hcount), .in_vcount(in_vcount), .in_hsync(in_hsync),
      .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk), .in_rgb(in_rgb),
      .out_hcount(hcount_a), .out_vcount(vcount_a), .out_hsync(hsync_a),
      .out_vsync(vsync_a), .out_hblnk(hblnk_a), .out_vblnk(vblnk_a), .out_rgb(rgb_a),
      .frame_start(start_a), .frame_cnt(fcnt_a)
   );

   vga_bus_pipe #(.HC_W(HC_W), .VC_W(VC_W), .RGB_W(RGB_W), .DELAY(DELAY_B),
                  .BLANK_FORCE(1'b0), .SYNC_POL(1'b1), .FRAME_W(FW_B)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_hcount(in_hcount), .in_vcount(in_vcount), .in_hsync(in_hsync),
      .in_vsync(in_vsync), .in_hblnk(in_hblnk), .in_vblnk(in_vblnk), .in_rgb(in_rgb),
      .out_hcount(hcount_b), .out_vcount(vcount_b), .out_hsync(hsync_b),
      .out_vsync(vsync_b), .out_hblnk(hblnk_b), .out_vblnk(vblnk_b), .out_rgb(rgb_b),
      .frame_start(start_b), .frame_cnt(fcnt_b)
   );

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   // ---------------- scoreboard state ----------------
   logic [EXP_W-1:0] exp_q_a[$];
   logic [EXP_W-1:0] exp_q_b[$];
   int               checks = 0;
   int               passed = 0;
   bit               prev_vs_a, prev_vs_b;
   logic [FW_A-1:0]  cnt_a;
   logic [FW_B-1:0]  cnt_b;
   int               pulses_a, pulses_b;
   bit               seen_a;
   logic [FW_A-1:0]  seq_a[$];

   typedef struct {
      logic             hb;
      logic             vb;
      logic [RGB_W-1:0] rgb;
      logic [RGB_W-1:0] exp_a;
      logic [RGB_W-1:0] exp_b;
   } vec_t;
   vec_t tbl[12];

   function automatic logic [EXP_W-1:0] bus_of_a();
      return {hcount_a, vcount_a, hsync_a, vsync_a, hblnk_a, vblnk_a, rgb_a};
   endfunction

   function automatic logic [EXP_W-1:0] bus_of_b();
      return {hcount_b, vcount_b, hsync_b, vsync_b, hblnk_b, vblnk_b, rgb_b};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic compare_outputs();
      logic [EXP_W-1:0] ea, eb;
      bit               sa, sb;
      if (exp_q_a.size() == 0 || exp_q_b.size() == 0) begin
         check("queue_underflow", 64'd1, 64'd0);
         return;
      end
      ea = exp_q_a.pop_front();
      eb = exp_q_b.pop_front();
      sa = (ea[VS_BIT] == 1'b0) && (prev_vs_a != 1'b0);
      sb = (eb[VS_BIT] == 1'b1) && (prev_vs_b != 1'b1);
      check("bus_a", 64'(bus_of_a()), 64'(ea));
      check("bus_b", 64'(bus_of_b()), 64'(eb));
      check("frame_start_a", 64'(start_a), 64'(sa));
      check("frame_start_b", 64'(start_b), 64'(sb));
      check("frame_cnt_a", 64'(fcnt_a), 64'(cnt_a));
      check("frame_cnt_b", 64'(fcnt_b), 64'(cnt_b));
      if (seen_a) seq_a.push_back(fcnt_a);
      seen_a = start_a;
      if (start_a) pulses_a++;
      if (start_b) pulses_b++;
      if (sa) cnt_a = cnt_a + 1'b1;
      if (sb) cnt_b = cnt_b + 1'b1;
      prev_vs_a = ea[VS_BIT];
      prev_vs_b = eb[VS_BIT];
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [HC_W-1:0] hc, input logic [VC_W-1:0] vc,
                        input logic hs, input logic vs, input logic hb, input logic vb,
                        input logic [RGB_W-1:0] rgb,
                        input logic [RGB_W-1:0] exp_rgb_a, input logic [RGB_W-1:0] exp_rgb_b);
      logic [TW-1:0] t;
      in_hcount = hc; in_vcount = vc; in_hsync = hs; in_vsync = vs;
      in_hblnk = hb;  in_vblnk = vb;  in_rgb = rgb;
      t = {hc, vc, hs, vs, hb, vb};
      exp_q_a.push_back({t, exp_rgb_a});
      exp_q_b.push_back({t, exp_rgb_b});
      @(posedge clk);
      #1;
      compare_outputs();
   endtask

   task automatic drive_auto(input logic [HC_W-1:0] hc, input logic [VC_W-1:0] vc,
                             input logic hs, input logic vs, input logic hb, input logic vb,
                             input logic [RGB_W-1:0] rgb);
      drive(hc, vc, hs, vs, hb, vb, rgb, (hb | vb) ? '0 : rgb, rgb);
   endtask

   // Asserts reset away from the clock edge, checks the asynchronous clear, then
   // releases and rebuilds the model: DELAY-1 zero entries precede the first live sample.
   task automatic do_reset(input int hold);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_bus_a", 64'(bus_of_a()), 64'd0);
      check("rst_bus_b", 64'(bus_of_b()), 64'd0);
      check("rst_cnt_a", 64'(fcnt_a), 64'd0);
      check("rst_cnt_b", 64'(fcnt_b), 64'd0);
      repeat (hold) @(posedge clk);
      #1;
      rst_n = 1'b1;
      exp_q_a.delete();
      exp_q_b.delete();
      for (int i = 0; i < DELAY_A - 1; i++) exp_q_a.push_back('0);
      for (int i = 0; i < DELAY_B - 1; i++) exp_q_b.push_back('0);
      prev_vs_a = 1'b0; prev_vs_b = 1'b0;
      cnt_a = '0; cnt_b = '0;
      pulses_a = 0; pulses_b = 0;
      seen_a = 1'b0;
      seq_a.delete();
      check("rel_bus_a", 64'(bus_of_a()), 64'd0);
      check("rel_bus_b", 64'(bus_of_b()), 64'd0);
      check("rel_start_a", 64'(start_a), 64'd0);
      check("rel_start_b", 64'(start_b), 64'd0);
   endtask

   // ---------------- test sequence ----------------
   initial begin
      logic [FW_A-1:0] exp_seq[5];
      logic hs, vs, hb, vb;

      tbl[0]  = '{1'b0, 1'b0, 12'hFFF, 12'hFFF, 12'hFFF};
      tbl[1]  = '{1'b1, 1'b0, 12'hFFF, 12'h000, 12'hFFF};
      tbl[2]  = '{1'b1, 1'b0, 12'hFFF, 12'h000, 12'hFFF};
      tbl[3]  = '{1'b1, 1'b0, 12'hFFF, 12'h000, 12'hFFF};
      tbl[4]  = '{1'b1, 1'b0, 12'hFFF, 12'h000, 12'hFFF};
      tbl[5]  = '{1'b0, 1'b0, 12'hFFF, 12'hFFF, 12'hFFF};
      tbl[6]  = '{1'b0, 1'b1, 12'hABC, 12'h000, 12'hABC};
      tbl[7]  = '{1'b1, 1'b1, 12'h123, 12'h000, 12'h123};
      tbl[8]  = '{1'b0, 1'b0, 12'h5A5, 12'h5A5, 12'h5A5};
      tbl[9]  = '{1'b0, 1'b1, 12'hFFF, 12'h000, 12'hFFF};
      tbl[10] = '{1'b0, 1'b0, 12'h000, 12'h000, 12'h000};
      tbl[11] = '{1'b0, 1'b0, 12'hFFF, 12'hFFF, 12'hFFF};
      exp_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      repeat (2) @(posedge clk);
      #1;
      do_reset(2);

      // Ramp on hcount: zeros for DELAY cycles then 0,1,2,... on every field.
      for (int i = 0; i < 12; i++)
         drive_auto(HC_W'(i), VC_W'(5), 1'b1, 1'b1, 1'b0, 1'b0, RGB_W'(i * 16 + 3));

      // Blanking vectors, including a 4-cycle hblnk burst on full-white rgb.
      for (int i = 0; i < 12; i++)
         drive(HC_W'(100 + i), VC_W'(7), 1'b1, 1'b1, tbl[i].hb, tbl[i].vb,
               tbl[i].rgb, tbl[i].exp_a, tbl[i].exp_b);
      for (int i = 0; i < 6; i++)
         drive_auto(HC_W'(200 + i), VC_W'(7), 1'b1, 1'b1, 1'b0, 1'b0, 12'h777);

      // Reset mid-line: in-flight data is dropped, live data returns DELAY cycles later.
      for (int i = 0; i < 6; i++)
         drive_auto(HC_W'(300 + i), VC_W'(8), 1'b1, 1'b1, 1'b0, 1'b0, RGB_W'(i + 1));
      do_reset(2);
      for (int i = 0; i < 10; i++)
         drive_auto(HC_W'(400 + i), VC_W'(8), 1'b1, 1'b1, 1'b0, 1'b0, RGB_W'(i + 9));

      // Scaled timing source, 5 frames; vsync is active-low for lines 9-10.
      do_reset(1);
      for (int f = 0; f < 5; f++)
         for (int v = 0; v < V_TOT; v++)
            for (int h = 0; h < H_TOT; h++) begin
               hs = !(h >= 16 && h <= 18);
               hb = (h >= 16);
               vs = !(v == 9 || v == 10);
               vb = (v >= 9);
               drive_auto(HC_W'(h), VC_W'(v), hs, vs, hb, vb,
                          RGB_W'($urandom_range(0, 4095)));
            end
      for (int i = 0; i < 6; i++)
         drive_auto('0, '0, 1'b1, 1'b1, 1'b0, 1'b0, '0);
      check("pulses_a", 64'(pulses_a), 64'd5);
      // Active-high instance also sees the 0->1 step of vsync right after reset.
      check("pulses_b", 64'(pulses_b), 64'd6);
      check("final_cnt_a", 64'(fcnt_a), 64'd1);
      check("final_cnt_b", 64'(fcnt_b), 64'd6);
      check("seq_len_a", 64'(seq_a.size()), 64'd5);
      for (int i = 0; i < 5 && i < seq_a.size(); i++)
         check("cnt_seq_a", 64'(seq_a[i]), 64'(exp_seq[i]));

      // Random bus with occasional single-cycle vsync glitches.
      for (int i = 0; i < 150; i++)
         drive_auto(HC_W'($urandom_range(0, 2047)), VC_W'($urandom_range(0, 2047)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 7) != 0),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                    RGB_W'($urandom_range(0, 4095)));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/vga_bus_pipe.md
VGA_BUS_PIPE -- requirements
Module: vga_bus_pipe

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 Parameters SHALL be as follows, one per line (name, default, meaning):
- HC_W, 11, hcount width.
- VC_W, 11, vcount width.
- RGB_W, 12, rgb width.
- DELAY, 1, pipeline depth in cycles; legal range 1..16.
- BLANK_FORCE, 1, when 1, rgb is zeroed during blanking.
- SYNC_POL, 0, active level of hsync/vsync (0 = active-low).
- FRAME_W, 16, frame counter width.
REQ-003 Ports SHALL be as follows, one per line (name, direction, width, meaning):
- clk, in, 1, pixel clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_hcount, in, HC_W, horizontal count.
- in_vcount, in, VC_W, vertical count.
- in_hsync, in, 1, horizontal sync.
- in_vsync, in, 1, vertical sync.
- in_hblnk, in, 1, horizontal blank.
- in_vblnk, in, 1, vertical blank.
- in_rgb, in, RGB_W, pixel colour.
- out_hcount, out, HC_W, delayed hcount.
- out_vcount, out, VC_W, delayed vcount.
- out_hsync, out, 1, delayed hsync.
- out_vsync, out, 1, delayed vsync.
- out_hblnk, out, 1, delayed hblnk.
- out_vblnk, out, 1, delayed vblnk.
- out_rgb, out, RGB_W, delayed and optionally blank-forced rgb.
- frame_start, out, 1, one-cycle pulse on the vsync active edge at the output.
- frame_cnt, out, FRAME_W, count of frame_start pulses.

Function
REQ-004 Every out_* timing field SHALL equal the corresponding in_* value sampled exactly DELAY rising edges earlier.
REQ-005 All bus fields SHALL travel in a single shift structure so that hcount, vcount, syncs, blanks and rgb remain mutually aligned at every depth.
REQ-006 With BLANK_FORCE=1, out_rgb SHALL be 0 in any cycle where out_hblnk | out_vblnk = 1; otherwise out_rgb SHALL be the delayed in_rgb.
REQ-007 With BLANK_FORCE=0, out_rgb SHALL be the delayed in_rgb unmodified.
REQ-008 Blank forcing SHALL NOT add latency; rgb latency SHALL equal DELAY.
REQ-009 A registered copy of out_vsync (vs_q) SHALL be held; a vsync active edge SHALL be defined as out_vsync == SYNC_POL and vs_q != SYNC_POL.
REQ-010 frame_start SHALL be 1 exactly in the cycles of a vsync active edge, and 0 otherwise; it SHALL have no added latency relative to out_vsync.
REQ-011 frame_cnt SHALL increment by 1 on the clock edge that ends a frame_start cycle.
REQ-012 frame_cnt SHALL wrap from 2^FRAME_W-1 to 0 with no flag.
REQ-013 A vsync held at its active level for many cycles SHALL produce one pulse only; a one-cycle active glitch SHALL produce one pulse.
REQ-014 The block SHALL have no stall, enable or backpressure; it SHALL accept one pixel per clock unconditionally.
REQ-015 A DELAY value outside 1..16 SHALL cause an elaboration-time error.

Reset
REQ-016 While rst_n=0, all pipeline stages, vs_q and frame_cnt SHALL be 0, asynchronously.
REQ-017 On reset release, outputs SHALL reflect pipeline contents: zeros for the first DELAY cycles, then live data.
REQ-018 Stage reset values SHALL be literal 0 regardless of SYNC_POL; with SYNC_POL=0, a reset-cleared out_vsync=0 following vs_q=0 SHALL NOT produce a pulse (vs_q reset 0 means an edge needs out_vsync=0 while vs_q=1).
REQ-019 Reset asserted mid-frame SHALL discard in-flight data; there SHALL be no partial-frame recovery.

Verification
REQ-020 DELAY=3, ramp in_hcount 0,1,2,... -> out_hcount = 0,0,0,0,1,2 over the first cycles after reset release; all fields stay aligned.
REQ-021 BLANK_FORCE=1, in_rgb=12'hFFF, in_hblnk pulsed high for 4 cycles -> out_rgb=0 for exactly those 4 cycles, DELAY cycles later.
REQ-022 SYNC_POL=0, 800x525 timing source, run 3 frames -> 3 frame_start pulses, each coincident with the out_vsync falling edge, and frame_cnt=3.
REQ-023 FRAME_W=2, 5 frames -> frame_cnt sequence 1,2,3,0,1.
REQ-024 rst_n pulsed low mid-line at DELAY=4 -> all outputs 0 immediately; outputs resume exactly 4 cycles after release.
REQ-025 SYNC_POL=1, vsync held high for 2 lines -> single frame_start pulse.
